// File: rtl/probe_pkg.sv
// Shared definitions for the probe scheduler and the host register map.
// Contents: scheduler state encoding, interval/group widths and the default
// acknowledge timeout and minimum interval.
package probe_pkg;

  localparam int unsigned INTERVAL_W       = 32;
  localparam int unsigned GROUP_W          = 16;
  localparam int unsigned ACK_TIMEOUT_DEF  = 16;
  localparam int unsigned MIN_INTERVAL_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/probe_scheduler_if.sv
// Host / transceiver signal bundle of the probe scheduler.
// master: the scheduler (takes host requests and TRANSC_BUSY, drives the rest).
// slave : the environment (host command decoder plus signal_transceiver).
interface probe_scheduler_if #(
  parameter int unsigned INTERVAL_W = probe_pkg::INTERVAL_W,
  parameter int unsigned GROUP_W    = probe_pkg::GROUP_W
);

  logic                  RUN_REQ;
  logic                  STOP_REQ;
  logic [GROUP_W-1:0]    GROUPS_NUMBER;
  logic [INTERVAL_W-1:0] PROBE_INTERVAL;
  logic                  TRANSC_BUSY;
  logic                  START_PROBE;
  logic                  SCHED_BUSY;
  logic [GROUP_W-1:0]    GROUP_CNT;
  logic                  DONE;
  logic                  OVERRUN;
  logic                  ACK_ERR;

  modport master (
    input  RUN_REQ, STOP_REQ, GROUPS_NUMBER, PROBE_INTERVAL, TRANSC_BUSY,
    output START_PROBE, SCHED_BUSY, GROUP_CNT, DONE, OVERRUN, ACK_ERR
  );

  modport slave (
    output RUN_REQ, STOP_REQ, GROUPS_NUMBER, PROBE_INTERVAL, TRANSC_BUSY,
    input  START_PROBE, SCHED_BUSY, GROUP_CNT, DONE, OVERRUN, ACK_ERR
  );

endinterface

// File: rtl/interval_timer.sv
// Loadable down-counter that saturates at zero.
// Ports: CLOCK_10M/RESET (async, active-high); load strobes value into the
// counter; zero is a registered flag, high while the count is 0.
module interval_timer
  import probe_pkg::*;
#(
  parameter int unsigned W = INTERVAL_W
) (
  input  logic         CLOCK_10M,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  // Zero tracks the next count so it is available as a plain register.
  always_ff @(posedge CLOCK_10M or posedge RESET) begin
    if (RESET) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= value;
      zero  <= (value == '0);
    end else if (count != '0) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/probe_scheduler.sv
// Probe scheduler: fires START_PROBE at the transceiver GROUPS_NUMBER times
// (0 = until STOP_REQ), start-to-start spaced by PROBE_INTERVAL cycles, and
// follows each probe through the TRANSC_BUSY handshake.
// Ports: CLOCK_10M, RESET (async, active-high); bus (master modport) carries
// RUN_REQ/STOP_REQ/GROUPS_NUMBER/PROBE_INTERVAL/TRANSC_BUSY in and
// START_PROBE/SCHED_BUSY/GROUP_CNT/DONE/OVERRUN/ACK_ERR out, all registered.
// INTERVAL_W must match the width of the connected interface instance.
module probe_scheduler
  import probe_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int unsigned INTERVAL_W   = probe_pkg::INTERVAL_W,
  parameter int unsigned MIN_INTERVAL = MIN_INTERVAL_DEF
) (
  input logic               CLOCK_10M,
  input logic               RESET,
  probe_scheduler_if.master bus
);

  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

  state_e                state;
  logic                  run_req_q;
  logic                  stop_pending;
  logic [GROUP_W-1:0]    groups_q;
  logic [INTERVAL_W-1:0] interval_q;
  logic [ACK_W-1:0]      ack_cnt;

  logic                  start_probe;
  logic                  sched_busy;
  logic [GROUP_W-1:0]    group_cnt;
  logic                  done;
  logic                  overrun;
  logic                  ack_err;

  logic                  run_edge;
  logic                  timer_load;
  logic                  timer_zero;
  logic [INTERVAL_W-1:0] timer_value;
  logic [INTERVAL_W-1:0] interval_clamped;
  logic [GROUP_W-1:0]    cnt_next;
  logic                  last_probe;

  assign run_edge = bus.RUN_REQ & ~run_req_q;

  assign interval_clamped = (bus.PROBE_INTERVAL < INTERVAL_W'(MIN_INTERVAL)) ?
                            INTERVAL_W'(MIN_INTERVAL) : bus.PROBE_INTERVAL;

  // Load on the first ARM cycle. The count is shortened by two so that zero
  // is seen in WAIT one cycle before the next START_PROBE must be high,
  // absorbing the load cycle and the registered ARM transition.
  assign timer_load  = (state == ARM) && (ack_cnt == '0);
  assign timer_value = interval_q - INTERVAL_W'(2);

  assign cnt_next   = group_cnt + GROUP_W'(1);
  assign last_probe = ((groups_q != '0) && (cnt_next == groups_q)) ||
                      stop_pending || bus.STOP_REQ;

  interval_timer #(.W(INTERVAL_W)) u_timer (
    .CLOCK_10M (CLOCK_10M),
    .RESET     (RESET),
    .load      (timer_load),
    .value     (timer_value),
    .zero      (timer_zero)
  );

  // Run sequencer with registered outputs.
  always_ff @(posedge CLOCK_10M or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      run_req_q    <= 1'b0;
      stop_pending <= 1'b0;
      groups_q     <= '0;
      interval_q   <= '0;
      ack_cnt      <= '0;
      start_probe  <= 1'b0;
      sched_busy   <= 1'b0;
      group_cnt    <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      run_req_q <= bus.RUN_REQ;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (run_edge) begin
            groups_q     <= bus.GROUPS_NUMBER;
            interval_q   <= interval_clamped;
            group_cnt    <= '0;
            overrun      <= 1'b0;
            ack_err      <= 1'b0;
            stop_pending <= 1'b0;
            sched_busy   <= 1'b1;
            start_probe  <= 1'b1;
            ack_cnt      <= '0;
            state        <= ARM;
          end
        end
        ARM: begin
          if (bus.STOP_REQ) stop_pending <= 1'b1;
          if (bus.TRANSC_BUSY) begin
            start_probe <= 1'b0;
            state       <= RUN;
          end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            start_probe <= 1'b0;
            ack_err     <= 1'b1;
            sched_busy  <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
          end
        end
        RUN: begin
          if (!bus.TRANSC_BUSY) begin
            group_cnt <= cnt_next;
            if (last_probe) begin
              sched_busy <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              // Timer already expired: the next probe will start late.
              if (timer_zero) overrun <= 1'b1;
              state <= WAIT;
            end
          end else if (bus.STOP_REQ) begin
            stop_pending <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.STOP_REQ) begin
            sched_busy <= 1'b0;
            done       <= 1'b1;
            state      <= FINISH;
          end else if (timer_zero) begin
            start_probe <= 1'b1;
            ack_cnt     <= '0;
            state       <= ARM;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          start_probe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.START_PROBE = start_probe;
  assign bus.SCHED_BUSY  = sched_busy;
  assign bus.GROUP_CNT   = group_cnt;
  assign bus.DONE        = done;
  assign bus.OVERRUN     = overrun;
  assign bus.ACK_ERR     = ack_err;

endmodule
